// File: rtl/decode_stage.sv
// RV32I/RV64I (+ optional M) instruction decoder with a handshaked ID/EX output register.
// One instruction per cycle when execute keeps up; stalls hold the bundle, flush and rst clear it.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter bit EN_MEXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      alu_op,
    output logic            alu_src0_sel,
    output logic            alu_src1_sel,
    output logic [4:0]      rf_ra0,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_wa,
    output logic            rs1_used,
    output logic            rs2_used,
    output logic            rf_we,
    output logic [1:0]      rf_wd_sel,
    output logic [3:0]      dmem_access,
    output logic            dmem_we,
    output logic [3:0]      br_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_LUI  = 5'b01010;

    typedef struct packed {
        logic [4:0]      alu_op;
        logic            alu_src0_sel;
        logic            alu_src1_sel;
        logic [4:0]      rf_ra0;
        logic [4:0]      rf_ra1;
        logic [4:0]      rf_wa;
        logic            rs1_used;
        logic            rs2_used;
        logic            rf_we;
        logic [1:0]      rf_wd_sel;
        logic [3:0]      dmem_access;
        logic            dmem_we;
        logic [3:0]      br_type;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    function automatic bundle_t nop_bundle();
        bundle_t b;
        b           = '0;
        b.br_type   = 4'b1111;
        b.rf_wd_sel = 2'b01;
        return b;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        logic signed [XLEN-1:0] r;
        r = XLEN'(v);
        return r;
    endfunction

    // funct3 -> ALU op shared by OP and OP-IMM (arithmetic-shift selection handled by caller)
    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic [5:0] shamt;
    logic       shift_upper_zero, shift_upper_sra;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    // shamt is one bit wider on RV64, so the "must be zero" upper field is one bit narrower
    assign shamt            = RV64 ? inst[25:20] : {1'b0, inst[24:20]};
    assign shift_upper_zero = RV64 ? (inst[31:26] == 6'b0) : (inst[31:25] == 7'b0);
    assign shift_upper_sra  = RV64 ? (inst[31:26] == 6'b010000) : (inst[31:25] == 7'b0100000);

    bundle_t dec_p0, bundle_p1;
    logic    ill_p0;
    logic    vld_p1;
    logic [XLEN-1:0] pc_p1;

    // Stage p0: combinational decode of the presented instruction
    always_comb begin
        dec_p0 = nop_bundle();
        ill_p0 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_p0.alu_op = ALU_LUI;  dec_p0.alu_src1_sel = 1'b1;
                dec_p0.rf_we  = 1'b1;     dec_p0.rf_wa = rd;  dec_p0.imm = sext32(imm_u);
            end
            OPC_AUIPC: begin
                dec_p0.alu_src0_sel = 1'b1;  dec_p0.alu_src1_sel = 1'b1;
                dec_p0.rf_we = 1'b1;  dec_p0.rf_wa = rd;  dec_p0.imm = sext32(imm_u);
            end
            OPC_JAL: begin
                dec_p0.alu_src0_sel = 1'b1;  dec_p0.alu_src1_sel = 1'b1;
                dec_p0.rf_we = 1'b1;  dec_p0.rf_wa = rd;  dec_p0.rf_wd_sel = 2'b00;
                dec_p0.br_type = 4'b1100;  dec_p0.imm = sext32(imm_j);
            end
            OPC_JALR: begin
                dec_p0.rs1_used = 1'b1;  dec_p0.rf_ra0 = rs1;  dec_p0.alu_src1_sel = 1'b1;
                dec_p0.rf_we = 1'b1;  dec_p0.rf_wa = rd;  dec_p0.rf_wd_sel = 2'b00;
                dec_p0.br_type = 4'b1000;  dec_p0.imm = sext32(imm_i);
                ill_p0 = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_p0.rs1_used = 1'b1;  dec_p0.rf_ra0 = rs1;
                dec_p0.rs2_used = 1'b1;  dec_p0.rf_ra1 = rs2;
                dec_p0.alu_src0_sel = 1'b1;  dec_p0.alu_src1_sel = 1'b1;
                dec_p0.br_type = {1'b0, funct3};  dec_p0.imm = sext32(imm_b);
                ill_p0 = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_p0.rs1_used = 1'b1;  dec_p0.rf_ra0 = rs1;  dec_p0.alu_src1_sel = 1'b1;
                dec_p0.rf_we = 1'b1;  dec_p0.rf_wa = rd;  dec_p0.rf_wd_sel = 2'b10;
                dec_p0.imm = sext32(imm_i);
                case (funct3)
                    3'b000:  dec_p0.dmem_access = 4'b0100;
                    3'b001:  dec_p0.dmem_access = 4'b0101;
                    3'b010:  dec_p0.dmem_access = 4'b0110;
                    3'b100:  dec_p0.dmem_access = 4'b0000;
                    3'b101:  dec_p0.dmem_access = 4'b0001;
                    3'b110:  begin dec_p0.dmem_access = 4'b0010; ill_p0 = !RV64; end
                    3'b011:  begin dec_p0.dmem_access = 4'b0111; ill_p0 = !RV64; end
                    default: ill_p0 = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_p0.rs1_used = 1'b1;  dec_p0.rf_ra0 = rs1;
                dec_p0.rs2_used = 1'b1;  dec_p0.rf_ra1 = rs2;
                dec_p0.alu_src1_sel = 1'b1;  dec_p0.imm = sext32(imm_s);
                dec_p0.dmem_access = {1'b1, funct3};  dec_p0.dmem_we = 1'b1;
                ill_p0 = RV64 ? funct3[2] : (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                dec_p0.rs1_used = 1'b1;  dec_p0.rf_ra0 = rs1;  dec_p0.alu_src1_sel = 1'b1;
                dec_p0.rf_we = 1'b1;  dec_p0.rf_wa = rd;
                dec_p0.alu_op = alu_base(funct3);  dec_p0.imm = sext32(imm_i);
                if (funct3 == 3'b001) begin
                    dec_p0.imm = XLEN'(shamt);
                    ill_p0     = !shift_upper_zero;
                end else if (funct3 == 3'b101) begin
                    dec_p0.imm = XLEN'(shamt);
                    if (shift_upper_sra) dec_p0.alu_op = ALU_SRA;
                    ill_p0 = !(shift_upper_zero || shift_upper_sra);
                end
            end
            OPC_OP: begin
                dec_p0.rs1_used = 1'b1;  dec_p0.rf_ra0 = rs1;
                dec_p0.rs2_used = 1'b1;  dec_p0.rf_ra1 = rs2;
                dec_p0.rf_we = 1'b1;  dec_p0.rf_wa = rd;
                case (funct7)
                    7'b0000000: dec_p0.alu_op = alu_base(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_p0.alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) dec_p0.alu_op = ALU_SRA;
                        else                       ill_p0 = 1'b1;
                    end
                    7'b0000001: begin
                        dec_p0.alu_op = {2'b10, funct3};
                        ill_p0 = !EN_MEXT;
                    end
                    default: ill_p0 = 1'b1;
                endcase
            end
            default: ill_p0 = 1'b1;
        endcase
        if (ill_p0) begin
            dec_p0         = nop_bundle();
            dec_p0.illegal = 1'b1;
        end
    end

    assign in_ready = !vld_p1 || out_ready;

    // Stage p1: ID/EX register
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1    <= 1'b0;
            bundle_p1 <= nop_bundle();
            pc_p1     <= '0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                bundle_p1 <= dec_p0;
                pc_p1     <= pc;
            end
        end
    end

    assign out_valid    = vld_p1;
    assign out_pc       = pc_p1;
    assign alu_op       = bundle_p1.alu_op;
    assign alu_src0_sel = bundle_p1.alu_src0_sel;
    assign alu_src1_sel = bundle_p1.alu_src1_sel;
    assign rf_ra0       = bundle_p1.rf_ra0;
    assign rf_ra1       = bundle_p1.rf_ra1;
    assign rf_wa        = bundle_p1.rf_wa;
    assign rs1_used     = bundle_p1.rs1_used;
    assign rs2_used     = bundle_p1.rs2_used;
    assign rf_we        = bundle_p1.rf_we;
    assign rf_wd_sel    = bundle_p1.rf_wd_sel;
    assign dmem_access  = bundle_p1.dmem_access;
    assign dmem_we      = bundle_p1.dmem_we;
    assign br_type      = bundle_p1.br_type;
    assign imm          = bundle_p1.imm;
    assign illegal      = bundle_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, stall, flush, reset and decode of representative encodings.
// A second instance built without the M extension checks that MUL becomes illegal there.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] inst, pc;

    logic        in_ready, out_valid, alu_src0_sel, alu_src1_sel, rs1_used, rs2_used;
    logic        rf_we, dmem_we, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  alu_op, rf_ra0, rf_ra1, rf_wa;
    logic [1:0]  rf_wd_sel;
    logic [3:0]  dmem_access, br_type;

    logic        n_in_ready, n_out_valid, n_src0, n_src1, n_rs1_used, n_rs2_used;
    logic        n_rf_we, n_dmem_we, n_illegal;
    logic [31:0] n_out_pc, n_imm;
    logic [4:0]  n_alu_op, n_ra0, n_ra1, n_wa;
    logic [1:0]  n_wd_sel;
    logic [3:0]  n_dmem_access, n_br_type;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EN_MEXT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_op(alu_op), .alu_src0_sel(alu_src0_sel), .alu_src1_sel(alu_src1_sel),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_wa(rf_wa), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rf_we(rf_we), .rf_wd_sel(rf_wd_sel), .dmem_access(dmem_access), .dmem_we(dmem_we),
        .br_type(br_type), .imm(imm), .illegal(illegal)
    );

    decode_stage #(.XLEN(32), .EN_MEXT(1'b0)) u_dut_nom (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .inst(inst), .pc(pc),
        .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
        .alu_op(n_alu_op), .alu_src0_sel(n_src0), .alu_src1_sel(n_src1),
        .rf_ra0(n_ra0), .rf_ra1(n_ra1), .rf_wa(n_wa), .rs1_used(n_rs1_used), .rs2_used(n_rs2_used),
        .rf_we(n_rf_we), .rf_wd_sel(n_wd_sel), .dmem_access(n_dmem_access), .dmem_we(n_dmem_we),
        .br_type(n_br_type), .imm(n_imm), .illegal(n_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; inst = '0; pc = '0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (br_type !== 4'b1111) begin bad++; $display("FAIL rst_br_type got=%b exp=1111", br_type); end
        total++; if (rf_wd_sel !== 2'b01) begin bad++; $display("FAIL rst_wd_sel got=%b exp=01", rf_wd_sel); end
        total++; if (imm !== 32'h0 || out_pc !== 32'h0 || rf_we !== 1'b0 || alu_op !== 5'b0) begin
            bad++; $display("FAIL rst_fields imm=%h pc=%h we=%b op=%b exp all 0", imm, out_pc, rf_we, alu_op);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1; in_valid = 1'b1;
        inst = 32'h00500093; pc = 32'h100;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            bad++; $display("FAIL addi_vld_pc got=%b/%h exp=1/00000100", out_valid, out_pc);
        end
        total++; if (alu_op !== 5'b00000 || imm !== 32'd5 || rf_wa !== 5'd1 || rs2_used !== 1'b0) begin
            bad++; $display("FAIL addi_fields op=%b imm=%h wa=%0d rs2u=%b exp 00000/5/1/0", alu_op, imm, rf_wa, rs2_used);
        end
        total++; if (alu_src1_sel !== 1'b1 || rf_we !== 1'b1 || rs1_used !== 1'b1 || rf_ra1 !== 5'd0) begin
            bad++; $display("FAIL addi_ctl src1=%b we=%b rs1u=%b ra1=%0d exp 1/1/1/0", alu_src1_sel, rf_we, rs1_used, rf_ra1);
        end
        inst = 32'h402081B3; pc = 32'h104;
        step();
        total++; if (alu_op !== 5'b00001 || rf_wa !== 5'd3 || rf_ra0 !== 5'd1 || rf_ra1 !== 5'd2 || alu_src1_sel !== 1'b0) begin
            bad++; $display("FAIL sub_fields op=%b wa=%0d ra0=%0d ra1=%0d src1=%b exp 00001/3/1/2/0", alu_op, rf_wa, rf_ra0, rf_ra1, alu_src1_sel);
        end
        inst = 32'hFE208EE3; pc = 32'h108;
        step();
        total++; if (br_type !== 4'b0000 || imm !== 32'hFFFFFFFC || alu_src0_sel !== 1'b1 || rf_we !== 1'b0) begin
            bad++; $display("FAIL beq_fields br=%b imm=%h src0=%b we=%b exp 0000/fffffffc/1/0", br_type, imm, alu_src0_sel, rf_we);
        end
        total++; if (out_pc !== 32'h108 || out_valid !== 1'b1) begin
            bad++; $display("FAIL beq_pc got=%h/%b exp=00000108/1", out_pc, out_valid);
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; out_ready = 1'b0; inst = 32'h00812203; pc = 32'h200;
        step();
        inst = 32'h00500093; pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200) begin
                bad++; $display("FAIL stall_hold%0d rdy=%b vld=%b pc=%h exp 0/1/00000200", i, in_ready, out_valid, out_pc);
            end
            total++; if (dmem_access !== 4'b0110 || rf_wd_sel !== 2'b10 || imm !== 32'd8 || rf_wa !== 5'd4 || rf_ra0 !== 5'd2) begin
                bad++; $display("FAIL stall_lw%0d acc=%b wd=%b imm=%h wa=%0d ra0=%0d exp 0110/10/8/4/2", i, dmem_access, rf_wd_sel, imm, rf_wa, rf_ra0);
            end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_rdy got=%b exp=1", in_ready); end
        step();
        total++; if (out_pc !== 32'h204 || alu_op !== 5'b00000 || imm !== 32'd5 || dmem_access !== 4'b0000 || rf_wd_sel !== 2'b01) begin
            bad++; $display("FAIL release_next pc=%h op=%b imm=%h acc=%b wd=%b exp 204/00000/5/0000/01", out_pc, alu_op, imm, dmem_access, rf_wd_sel);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mext();
        in_valid = 1'b1; out_ready = 1'b1; inst = 32'h027302B3; pc = 32'h300;
        step();
        total++; if (alu_op !== 5'b10000 || illegal !== 1'b0 || rf_we !== 1'b1 || rf_wa !== 5'd5) begin
            bad++; $display("FAIL mul_m op=%b ill=%b we=%b wa=%0d exp 10000/0/1/5", alu_op, illegal, rf_we, rf_wa);
        end
        total++; if (n_illegal !== 1'b1 || n_rf_we !== 1'b0 || n_out_valid !== 1'b1 || n_alu_op !== 5'b0 || n_br_type !== 4'b1111) begin
            bad++; $display("FAIL mul_nom ill=%b we=%b vld=%b op=%b br=%b exp 1/0/1/00000/1111", n_illegal, n_rf_we, n_out_valid, n_alu_op, n_br_type);
        end
        inst = 32'h027342B3;
        step();
        total++; if (alu_op !== 5'b10100 || illegal !== 1'b0) begin
            bad++; $display("FAIL div_m op=%b ill=%b exp 10100/0", alu_op, illegal);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_formats();
        logic [31:0] insts [5];
        insts = '{32'h40315093, 32'h800002B7, 32'h008000EF, 32'h000100E7, 32'h0020A623};
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inst = insts[i]; pc = 32'h400 + 32'(i * 4);
            step();
            total++; if (illegal !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL fmt%0d_legal ill=%b vld=%b exp 0/1", i, illegal, out_valid);
            end
            case (i)
                0: begin total++; if (alu_op !== 5'b00111 || imm !== 32'd3) begin
                       bad++; $display("FAIL srai op=%b imm=%h exp 00111/3", alu_op, imm); end end
                1: begin total++; if (alu_op !== 5'b01010 || imm !== 32'h80000000 || rs1_used !== 1'b0 || rf_wa !== 5'd5) begin
                       bad++; $display("FAIL lui op=%b imm=%h rs1u=%b wa=%0d exp 01010/80000000/0/5", alu_op, imm, rs1_used, rf_wa); end end
                2: begin total++; if (br_type !== 4'b1100 || rf_wd_sel !== 2'b00 || imm !== 32'd8 || alu_src0_sel !== 1'b1) begin
                       bad++; $display("FAIL jal br=%b wd=%b imm=%h src0=%b exp 1100/00/8/1", br_type, rf_wd_sel, imm, alu_src0_sel); end end
                3: begin total++; if (br_type !== 4'b1000 || rf_wd_sel !== 2'b00 || rf_ra0 !== 5'd2 || alu_src0_sel !== 1'b0) begin
                       bad++; $display("FAIL jalr br=%b wd=%b ra0=%0d src0=%b exp 1000/00/2/0", br_type, rf_wd_sel, rf_ra0, alu_src0_sel); end end
                default: begin total++; if (dmem_access !== 4'b1010 || dmem_we !== 1'b1 || rf_we !== 1'b0 || imm !== 32'd12 || rf_ra1 !== 5'd2) begin
                       bad++; $display("FAIL sw acc=%b dwe=%b we=%b imm=%h ra1=%0d exp 1010/1/0/c/2", dmem_access, dmem_we, rf_we, imm, rf_ra1); end end
            endcase
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] bad_insts [8];
        bad_insts = '{32'hFFFFFFFF, 32'hFE20AEE3, 32'h00813203, 32'h000110E7,
                      32'h02311093, 32'h4020C1B3, 32'h0020B623, 32'h802081B3};
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inst = bad_insts[i]; pc = 32'h500 + 32'(i * 4);
            step();
            total++; if (illegal !== 1'b1 || out_valid !== 1'b1 || rf_we !== 1'b0 || dmem_we !== 1'b0 || br_type !== 4'b1111) begin
                bad++; $display("FAIL ill%0d inst=%h ill=%b vld=%b we=%b dwe=%b br=%b exp 1/1/0/0/1111", i, bad_insts[i], illegal, out_valid, rf_we, dmem_we, br_type);
            end
            total++; if (imm !== 32'h0 || rf_wd_sel !== 2'b01 || alu_op !== 5'b0 || dmem_access !== 4'b0 || rs1_used !== 1'b0) begin
                bad++; $display("FAIL ill%0d_nop imm=%h wd=%b op=%b acc=%b rs1u=%b exp 0/01/0/0/0", i, imm, rf_wd_sel, alu_op, dmem_access, rs1_used);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b0; inst = 32'h00500093; pc = 32'h600;
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_vld got=%b exp=1", out_valid); end
        flush = 1'b1; out_ready = 1'b1; inst = 32'h402081B3; pc = 32'h604;
        step();
        total++; if (out_valid !== 1'b0 || br_type !== 4'b1111 || rf_we !== 1'b0 || rf_wd_sel !== 2'b01) begin
            bad++; $display("FAIL flush_nop vld=%b br=%b we=%b wd=%b exp 0/1111/0/01", out_valid, br_type, rf_we, rf_wd_sel);
        end
        flush = 1'b0; in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || alu_op !== 5'b00000) begin
            bad++; $display("FAIL flush_drop vld=%b op=%b exp 0/00000", out_valid, alu_op);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; out_ready = 1'b0; inst = 32'h00812203; pc = 32'h700;
        step();
        total++; if (out_valid !== 1'b1 || dmem_access !== 4'b0110) begin
            bad++; $display("FAIL rstmid_pre vld=%b acc=%b exp 1/0110", out_valid, dmem_access);
        end
        rst = 1'b1; in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || br_type !== 4'b1111 || rf_wd_sel !== 2'b01 || imm !== 32'h0 || dmem_access !== 4'b0 || out_pc !== 32'h0) begin
            bad++; $display("FAIL rstmid vld=%b br=%b wd=%b imm=%h acc=%b pc=%h exp 0/1111/01/0/0000/0", out_valid, br_type, rf_wd_sel, imm, dmem_access, out_pc);
        end
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_mext();
        test_formats();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32I/RV64I instruction decode stage with an optional M extension.
- Decodes a fetched instruction and PC into control fields for the execute stage, then holds them in an ID/EX output register.
- Supports back-pressure, flush, illegal-instruction detection and register-use flags for the hazard unit.
- Sits between the fetch stage and execute in the pipelined core.

Parameters:
- XLEN, 32, datapath width for imm/pc. Legal values are 32 and 64. Controls shamt width: 5 bits at 32, 6 bits at 64.
- EN_MEXT, 1, when 1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. When 0 these encodings are illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents inst/pc
- in_ready  out  1  stage accepts this cycle
- inst  in  32  instruction word
- pc  in  XLEN  instruction address
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  registered pc
- alu_op  out  5  ALU operation
- alu_src0_sel  out  1  0 = rs1, 1 = pc
- alu_src1_sel  out  1  0 = rs2, 1 = imm
- rf_ra0, rf_ra1, rf_wa  out  5 each  register addresses
- rs1_used, rs2_used  out  1 each  operand actually read
- rf_we  out  1  register write enable
- rf_wd_sel  out  2  00 pc+4, 01 ALU, 10 memory
- dmem_access  out  4  access type
- dmem_we  out  1  store
- br_type  out  4  branch type
- imm  out  XLEN  sign-extended immediate
- illegal  out  1  undecodable instruction

Behaviour:
- **Reset.** Synchronous and active-high.
  - The whole bundle resets to the NOP bundle: all fields 0 except br_type=4'b1111 and rf_wd_sel=2'b01.
  - out_valid=0 and out_pc=0.
- **Handshake.**
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer occurs when in_valid && in_ready. The decoded bundle and pc are registered on that edge, giving 1-cycle latency.
  - If out_valid && !out_ready, all outputs hold stable and no input is accepted.
  - If out_ready && !in_valid, out_valid clears next cycle.
- **Flush.** flush has priority over everything except rst.
  - Next cycle out_valid=0 and the bundle is the NOP bundle.
  - An input presented in the flush cycle is dropped.
  - in_ready stays as defined.
- **Decode encodings.**
  - alu_op: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SRL 00110, SRA 00111, SLT 01000, SLTU 01001, LUI-pass 01010.
  - alu_op (M extension): MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - Loads: dmem_access LB 0100, LH 0101, LW 0110, LBU 0000, LHU 0001. When XLEN=64 also LWU 0010 and LD 0111.
  - Stores: dmem_access={1,funct3}, dmem_we=1.
  - Branches: br_type={0,funct3}. JALR 1000, JAL 1100, otherwise 1111.
  - JAL/JALR: rf_wd_sel=00.
  - Loads: rf_wd_sel=10.
  - Branches, JAL and AUIPC: alu_src0_sel=1.
  - Immediates: I/S/B/U/J formats, sign-extended from inst[31] to XLEN.
  - rs1_used/rs2_used are set only when the format reads that register. rf_ra* is 0 when the register is not used.
  - rd=x0 decodes normally, with rf_we=1.
- **Illegal conditions.**
  - Unknown opcode.
  - Load funct3 011/110/111 at XLEN=32.
  - Store funct3>010 at XLEN=32.
  - Branch funct3 010/011.
  - JALR funct3≠000.
  - R-type funct7 not in {0000000, 0100000, 0000001 if EN_MEXT}.
  - funct7=0100000 with funct3 not 000/101.
  - Shift-immediate with a nonzero upper field: inst[31:25] at XLEN=32, inst[31:26] at XLEN=64, except SRAI's 0100000/010000.
- **Illegal response.** illegal=1, rf_we=0, dmem_we=0, br_type=1111, and all other fields take the NOP bundle. out_valid still asserts so the exception reaches commit.
- **Simultaneous events.** Accept and drain in the same cycle gives back-to-back throughput of 1 instruction per cycle. rst during a stall clears immediately on the edge.

Test Plan:
- **Reset mid-stream.** Assert rst for 1 cycle with out_valid=1 → out_valid=0, br_type=1111, rf_wd_sel=01, imm=0.
- **Streaming, out_ready=1.** Stream 0x00500093 (addi x1,x0,5), 0x402081B3 (sub x3,x1,x2), 0xFE208EE3 (beq x1,x2,-4) → one bundle per cycle, 1-cycle latency:
  - addi: alu_op=00000, imm=5, rf_wa=1, rs2_used=0.
  - sub: alu_op=00001.
  - beq: br_type=0000, imm=0xFFFFFFFC, alu_src0_sel=1, rf_we=0.
- **Stall.** Hold out_ready=0 for 3 cycles with 0x00812203 (lw x4,8(x2)) held → in_ready=0, bundle stable with dmem_access=0110, rf_wd_sel=10, imm=8. Releasing out_ready accepts the next instruction that cycle.
- **M extension.** Send 0x027302B3 (mul x5,x6,x7) with EN_MEXT=1 → alu_op=10000, illegal=0. With EN_MEXT=0 → illegal=1, rf_we=0.
- **Illegal instruction.** Send 0xFFFFFFFF → out_valid=1, illegal=1, rf_we=0, dmem_we=0, br_type=1111.
- **Flush.** Assert flush with out_valid=1 and in_valid=1 in the same cycle → next cycle out_valid=0 and the incoming instruction is not delivered later.
